// File: rtl/dice_pkg.sv
// Shared types for the dice game controller: state encoding, die width and
// round-result / winner codes.
package dice_pkg;

    localparam int unsigned DICE_W = 4;
    localparam int unsigned RES_W  = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ROLL1   = 3'd1,
        ST_SETTLE1 = 3'd2,
        ST_ROLL2   = 3'd3,
        ST_SETTLE2 = 3'd4,
        ST_JUDGE   = 3'd5,
        ST_SHOW    = 3'd6,
        ST_OVER    = 3'd7
    } state_e;

    localparam logic [RES_W-1:0] RES_NONE = 2'b00;
    localparam logic [RES_W-1:0] RES_P1   = 2'b01;
    localparam logic [RES_W-1:0] RES_P2   = 2'b10;
    localparam logic [RES_W-1:0] RES_DRAW = 2'b11;

    // Unsigned compare of the two held dice into a round-result code.
    function automatic logic [RES_W-1:0] judge_round(input logic [DICE_W-1:0] a,
                                                     input logic [DICE_W-1:0] b);
        if (a > b) return RES_P1;
        if (a < b) return RES_P2;
        return RES_DRAW;
    endfunction

endpackage

// File: rtl/dice_settle_timer.sv
// Loadable down-counter giving the die time to settle after a stop key;
// done_c fires in the last of SETTLE_CYC enabled cycles after a load.
module dice_settle_timer #(
    parameter int unsigned SETTLE_CYC = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic done_c
);

    localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(SETTLE_CYC - 1);
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_c = en && (cnt_q == '0);

endmodule

// File: rtl/dice_game_ctrl.sv
// Turn/round sequencer for the two-die game: roll/settle per player, judge, scores, winner.
// Optional DICE_DRAW_REROLL_EN: a drawn round restarts at ROLL1 without waiting for a key.
module dice_game_ctrl
    import dice_pkg::*;
#(
    parameter int unsigned WIN_SCORE  = 5,
    parameter int unsigned SETTLE_CYC = 250,
    parameter int unsigned SCORE_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key1,
    input  logic               key2,
    input  logic [DICE_W-1:0]  dice1,
    input  logic [DICE_W-1:0]  dice2,
    output logic               start1,
    output logic               start2,
    output logic               finish,
    output logic [DICE_W-1:0]  held1,
    output logic [DICE_W-1:0]  held2,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [RES_W-1:0]   round_res,
    output logic [RES_W-1:0]   winner
);

    state_e             state_q, state_d;
    logic               start1_q, start1_d;
    logic               start2_q, start2_d;
    logic               finish_q, finish_d;
    logic [DICE_W-1:0]  held1_q, held1_d;
    logic [DICE_W-1:0]  held2_q, held2_d;
    logic [SCORE_W-1:0] score1_q, score1_d;
    logic [SCORE_W-1:0] score2_q, score2_d;
    logic [RES_W-1:0]   round_res_q, round_res_d;
    logic [RES_W-1:0]   winner_q, winner_d;

    logic               tmr_load_c, tmr_en_c, tmr_done_c;
    logic [RES_W-1:0]   judge_c;
    logic               score1_win_c, score2_win_c;

    dice_settle_timer #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load_c),
        .en     (tmr_en_c),
        .done_c (tmr_done_c)
    );

    assign judge_c      = judge_round(held1_q, held2_q);
    assign score1_win_c = (score1_q == SCORE_W'(WIN_SCORE));
    assign score2_win_c = (score2_q == SCORE_W'(WIN_SCORE));

    // Next-state and next-output logic; start lines are high only while in a ROLL state.
    always_comb begin
        state_d     = state_q;
        start1_d    = 1'b0;
        start2_d    = 1'b0;
        finish_d    = finish_q;
        held1_d     = held1_q;
        held2_d     = held2_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        round_res_d = round_res_q;
        winner_d    = winner_q;
        tmr_load_c  = 1'b0;
        tmr_en_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (key1) begin
                    state_d  = ST_ROLL1;
                    start1_d = 1'b1;
                end
            end
            ST_ROLL1: begin
                round_res_d = RES_NONE;
                if (key1) begin
                    state_d    = ST_SETTLE1;
                    tmr_load_c = 1'b1;
                end else begin
                    start1_d = 1'b1;
                end
            end
            ST_SETTLE1: begin
                tmr_en_c = 1'b1;
                if (tmr_done_c) begin
                    held1_d  = dice1;
                    state_d  = ST_ROLL2;
                    start2_d = 1'b1;
                end
            end
            ST_ROLL2: begin
                if (key2) begin
                    state_d    = ST_SETTLE2;
                    tmr_load_c = 1'b1;
                end else begin
                    start2_d = 1'b1;
                end
            end
            ST_SETTLE2: begin
                tmr_en_c = 1'b1;
                if (tmr_done_c) begin
                    held2_d = dice2;
                    state_d = ST_JUDGE;
                end
            end
            ST_JUDGE: begin
                round_res_d = judge_c;
                state_d     = ST_SHOW;
                if ((judge_c == RES_P1) && (score1_q < SCORE_W'(WIN_SCORE))) begin
                    score1_d = score1_q + SCORE_W'(1);
                end
                if ((judge_c == RES_P2) && (score2_q < SCORE_W'(WIN_SCORE))) begin
                    score2_d = score2_q + SCORE_W'(1);
                end
`ifdef DICE_DRAW_REROLL_EN
                if (judge_c == RES_DRAW) begin
                    state_d  = ST_ROLL1;
                    start1_d = 1'b1;
                    held1_d  = '0;
                    held2_d  = '0;
                end
`endif
            end
            ST_SHOW: begin
                if (score1_win_c || score2_win_c) begin
                    state_d  = ST_OVER;
                    finish_d = 1'b1;
                    winner_d = score1_win_c ? RES_P1 : RES_P2;
                end else if (key1) begin
                    state_d     = ST_ROLL1;
                    start1_d    = 1'b1;
                    round_res_d = RES_NONE;
                    held1_d     = '0;
                    held2_d     = '0;
                end
            end
            ST_OVER: begin
                // Both keys together start a fresh match from a clean display.
                if (key1 && key2) begin
                    state_d     = ST_IDLE;
                    finish_d    = 1'b0;
                    winner_d    = RES_NONE;
                    score1_d    = '0;
                    score2_d    = '0;
                    round_res_d = RES_NONE;
                    held1_d     = '0;
                    held2_d     = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            start1_q    <= 1'b0;
            start2_q    <= 1'b0;
            finish_q    <= 1'b0;
            held1_q     <= '0;
            held2_q     <= '0;
            score1_q    <= '0;
            score2_q    <= '0;
            round_res_q <= RES_NONE;
            winner_q    <= RES_NONE;
        end else begin
            state_q     <= state_d;
            start1_q    <= start1_d;
            start2_q    <= start2_d;
            finish_q    <= finish_d;
            held1_q     <= held1_d;
            held2_q     <= held2_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            round_res_q <= round_res_d;
            winner_q    <= winner_d;
        end
    end

    assign start1    = start1_q;
    assign start2    = start2_q;
    assign finish    = finish_q;
    assign held1     = held1_q;
    assign held2     = held2_q;
    assign score1    = score1_q;
    assign score2    = score2_q;
    assign round_res = round_res_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_dice_game_ctrl.sv
// Self-checking bench for dice_game_ctrl: randomized rounds against a score/result model.
module tb_dice_game_ctrl;

    localparam int WIN = 5;
    localparam int S   = 250;

    logic       clk = 1'b0;
    logic       rst;
    logic       key1, key2;
    logic [3:0] dice1, dice2;
    logic       start1, start2, finish;
    logic [3:0] held1, held2, score1, score2;
    logic [1:0] round_res, winner;

    int checks = 0;
    int errors = 0;
    int m_s1   = 0;
    int m_s2   = 0;
    bit in_roll1 = 1'b0;

    dice_game_ctrl #(
        .WIN_SCORE  (WIN),
        .SETTLE_CYC (S),
        .SCORE_W    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key1      (key1),
        .key2      (key2),
        .dice1     (dice1),
        .dice2     (dice2),
        .start1    (start1),
        .start2    (start2),
        .finish    (finish),
        .held1     (held1),
        .held2     (held2),
        .score1    (score1),
        .score2    (score2),
        .round_res (round_res),
        .winner    (winner)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input bit k1, input bit k2);
        key1 = k1;
        key2 = k2;
        tick();
        key1 = 1'b0;
        key2 = 1'b0;
    endtask

    // Enter ROLL1 from IDLE or SHOW unless a draw reroll already put us there.
    task automatic next_round();
        if (!in_roll1) begin
            press(1'b1, 1'b0);
            checks++;
            if (start1 !== 1'b1 || round_res !== 2'b00 || held1 !== 4'd0 || held2 !== 4'd0) begin
                errors++;
                $display("FAIL next_round: start1=%0b res=%0b held1=%0d held2=%0d want 1 0 0 0",
                         start1, round_res, held1, held2);
            end
            in_roll1 = 1'b1;
        end
    endtask

    // Play one round starting in ROLL1; dice settle to d1/d2 only just before terminal count.
    task automatic roll_and_check(input logic [3:0] d1, input logic [3:0] d2, input bit noise);
        logic [1:0] exp_res;
        dice1 = (d1 % 4'd6) + 4'd1;
        press(1'b1, noise);
        checks++;
        if (start1 !== 1'b0 || start2 !== 1'b0) begin
            errors++;
            $display("FAIL stop1_start: start1=%0b start2=%0b want 0 0", start1, start2);
        end
        for (int i = 0; i < S; i++) begin
            if (i == S - 2) dice1 = d1;
            if (i == S - 1) begin
                checks++;
                if (held1 !== 4'd0 || start2 !== 1'b0) begin
                    errors++;
                    $display("FAIL settle1_early: held1=%0d start2=%0b want 0 0", held1, start2);
                end
            end
            key1 = noise && (i == 3 || i == 9);
            key2 = noise && (i == 3 || i == 7);
            tick();
        end
        key1 = 1'b0;
        key2 = 1'b0;
        dice1 = (d1 % 4'd6) + 4'd1;
        checks++;
        if (held1 !== d1 || start2 !== 1'b1) begin
            errors++;
            $display("FAIL settle1_latch: held1=%0d start2=%0b want %0d 1", held1, start2, d1);
        end
        if (noise) begin
            press(1'b1, 1'b0);
            checks++;
            if (start2 !== 1'b1 || start1 !== 1'b0) begin
                errors++;
                $display("FAIL roll2_key1: start1=%0b start2=%0b want 0 1", start1, start2);
            end
        end
        dice2 = (d2 % 4'd6) + 4'd1;
        press(noise, 1'b1);
        checks++;
        if (start2 !== 1'b0) begin
            errors++;
            $display("FAIL stop2_start: start2=%0b want 0", start2);
        end
        for (int i = 0; i < S; i++) begin
            if (i == S - 2) dice2 = d2;
            if (i == S - 1) begin
                checks++;
                if (held2 !== 4'd0) begin
                    errors++;
                    $display("FAIL settle2_early: held2=%0d want 0", held2);
                end
            end
            key1 = noise && (i == 3);
            key2 = noise && (i == 5);
            tick();
        end
        key1 = 1'b0;
        key2 = 1'b0;
        dice2 = (d2 % 4'd6) + 4'd1;
        checks++;
        if (held2 !== d2 || held1 !== d1 || round_res !== 2'b00) begin
            errors++;
            $display("FAIL judge_entry: held1=%0d held2=%0d res=%0b want %0d %0d 0",
                     held1, held2, round_res, d1, d2);
        end
        tick();
        exp_res = (d1 > d2) ? 2'b01 : ((d1 < d2) ? 2'b10 : 2'b11);
        if (exp_res == 2'b01) m_s1++;
        if (exp_res == 2'b10) m_s2++;
        checks++;
        if (round_res !== exp_res || score1 !== 4'(m_s1) || score2 !== 4'(m_s2)) begin
            errors++;
            $display("FAIL judge_result: res=%0b s1=%0d s2=%0d want %0b %0d %0d",
                     round_res, score1, score2, exp_res, m_s1, m_s2);
        end
        in_roll1 = 1'b0;
`ifdef DICE_DRAW_REROLL_EN
        if (exp_res == 2'b11) begin
            checks++;
            if (start1 !== 1'b1 || held1 !== 4'd0 || held2 !== 4'd0) begin
                errors++;
                $display("FAIL reroll_entry: start1=%0b held1=%0d held2=%0d want 1 0 0",
                         start1, held1, held2);
            end
            tick();
            checks++;
            if (round_res !== 2'b00 || start1 !== 1'b1) begin
                errors++;
                $display("FAIL reroll_clear: res=%0b start1=%0b want 0 1", round_res, start1);
            end
            in_roll1 = 1'b1;
        end
`endif
        if (!in_roll1) begin
            checks++;
            if (held1 !== d1 || held2 !== d2 || start1 !== 1'b0) begin
                errors++;
                $display("FAIL show_hold: held1=%0d held2=%0d start1=%0b want %0d %0d 0",
                         held1, held2, start1, d1, d2);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        key1 = 1'b0;
        key2 = 1'b0;
        dice1 = 4'd1;
        dice2 = 4'd1;
        repeat (3) tick();
        checks++;
        if ({start1, start2, finish, held1, held2, score1, score2, round_res, winner} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0",
                     {start1, start2, finish, held1, held2, score1, score2, round_res, winner});
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_first_round();
        next_round();
        repeat (40) tick();
        checks++;
        if (start1 !== 1'b1) begin
            errors++;
            $display("FAIL roll1_wait: start1=%0b want 1", start1);
        end
        roll_and_check(4'd5, 4'd3, 1'b0);
        checks++;
        if (score1 !== 4'd1 || round_res !== 2'b01) begin
            errors++;
            $display("FAIL first_round: s1=%0d res=%0b want 1 01", score1, round_res);
        end
    endtask

    task automatic test_draw();
        next_round();
        roll_and_check(4'd4, 4'd4, 1'b0);
        if (!in_roll1) begin
            repeat (3) tick();
            press(1'b0, 1'b1);
            checks++;
            if (round_res !== 2'b11 || held1 !== 4'd4 || start1 !== 1'b0 || score1 !== 4'd1) begin
                errors++;
                $display("FAIL draw_show: res=%0b held1=%0d start1=%0b s1=%0d want 11 4 0 1",
                         round_res, held1, start1, score1);
            end
        end
    endtask

    task automatic test_midround_reset();
        next_round();
        roll_and_check(4'd6, 4'd2, 1'b1);
        next_round();
        dice1 = 4'd3;
        press(1'b1, 1'b0);
        repeat (S) tick();
        press(1'b0, 1'b1);
        repeat (10) tick();
        checks++;
        if (score1 !== 4'd2) begin
            errors++;
            $display("FAIL pre_reset_score: s1=%0d want 2", score1);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({start1, start2, finish, held1, held2, score1, score2, round_res, winner} !== 23'd0) begin
            errors++;
            $display("FAIL midround_reset: got %h want 0",
                     {start1, start2, finish, held1, held2, score1, score2, round_res, winner});
        end
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({start1, start2, finish, score1, score2} !== 11'd0) begin
            errors++;
            $display("FAIL post_reset: got %h want 0", {start1, start2, finish, score1, score2});
        end
        m_s1 = 0;
        m_s2 = 0;
        in_roll1 = 1'b0;
    endtask

    task automatic test_ignored_keys();
        press(1'b0, 1'b1);
        checks++;
        if (start1 !== 1'b0 || start2 !== 1'b0) begin
            errors++;
            $display("FAIL idle_key2: start1=%0b start2=%0b want 0 0", start1, start2);
        end
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        checks++;
        if (start1 !== 1'b1 || start2 !== 1'b0) begin
            errors++;
            $display("FAIL roll1_key2: start1=%0b start2=%0b want 1 0", start1, start2);
        end
        in_roll1 = 1'b1;
    endtask

    task automatic test_p2_match();
        logic [3:0] d1, d2;
        for (int r = 0; r < WIN; r++) begin
            next_round();
            d1 = 4'($urandom_range(1, 5));
            d2 = 4'($urandom_range(6, 32'(d1) + 1));
            roll_and_check(d1, d2, r == 2);
        end
        tick();
        checks++;
        if (finish !== 1'b1 || winner !== 2'b10 || start1 !== 1'b0 || start2 !== 1'b0 || score2 !== 4'd5) begin
            errors++;
            $display("FAIL over_entry: finish=%0b winner=%0b s2=%0d want 1 10 5", finish, winner, score2);
        end
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        checks++;
        if (finish !== 1'b1 || winner !== 2'b10 || score2 !== 4'd5 || start1 !== 1'b0) begin
            errors++;
            $display("FAIL over_single_key: finish=%0b winner=%0b s2=%0d want 1 10 5", finish, winner, score2);
        end
        press(1'b1, 1'b1);
        checks++;
        if (finish !== 1'b0 || winner !== 2'b00 || score1 !== 4'd0 || score2 !== 4'd0) begin
            errors++;
            $display("FAIL over_exit: finish=%0b winner=%0b s1=%0d s2=%0d want 0 0 0 0",
                     finish, winner, score1, score2);
        end
        m_s1 = 0;
        m_s2 = 0;
        in_roll1 = 1'b0;
    endtask

    task automatic test_random_match();
        bit done = 1'b0;
        logic [1:0] exp_win;
        for (int r = 0; r < 40 && !done; r++) begin
            next_round();
            roll_and_check(4'($urandom_range(1, 6)), 4'($urandom_range(1, 6)), 1'($urandom_range(0, 1)));
            if (m_s1 == WIN || m_s2 == WIN) begin
                exp_win = (m_s1 == WIN) ? 2'b01 : 2'b10;
                tick();
                checks++;
                if (finish !== 1'b1 || winner !== exp_win) begin
                    errors++;
                    $display("FAIL random_winner: finish=%0b winner=%0b want 1 %0b", finish, winner, exp_win);
                end
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL random_match: no winner within 40 rounds (s1=%0d s2=%0d)", m_s1, m_s2);
        end
    endtask

    initial begin
        test_reset();
        test_first_round();
        test_draw();
        test_midround_reset();
        test_ignored_keys();
        test_p2_match();
        test_random_match();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
